// File: rtl/sl_pkg.sv
// Shared definitions for the SL receive deframer: FSM states, frame outcomes
// and the idle level of an SL line.
package sl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_PULSE0,
        ST_PULSE1,
        ST_GAP,
        ST_STOP
    } sl_state_e;

    typedef enum logic [1:0] {
        OUT_WRITE,
        OUT_PARITY_ERR,
        OUT_LEN_ERR,
        OUT_OVERFLOW
    } sl_outcome_e;

    localparam logic SL_IDLE_LVL = 1'b1;

    // Priority: length, then parity, then FIFO space.
    function automatic sl_outcome_e sl_frame_outcome(input logic len_ok,
                                                     input logic parity_ok,
                                                     input logic full);
        sl_outcome_e res;
        if (!len_ok)         res = OUT_LEN_ERR;
        else if (!parity_ok) res = OUT_PARITY_ERR;
        else if (full)       res = OUT_OVERFLOW;
        else                 res = OUT_WRITE;
        return res;
    endfunction

endpackage

// File: rtl/sl_line_filter.sv
// One SL line: 2-FF synchroniser followed by a run-length glitch filter that
// only moves the filtered level after MIN_PULSE equal synchronised samples.
module sl_line_filter
    import sl_pkg::*;
#(
    parameter int MIN_PULSE = 2
) (
    input  logic wr_clk,
    input  logic rd_rst_n,
    input  logic line_i,
    output logic level_o
);

    localparam int RUN_W = $clog2(MIN_PULSE + 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             level_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    always_comb begin
        level_d = level_q;
        run_d   = '0;
        if (sync_q != level_q) begin
            if (int'(run_q) + 1 >= MIN_PULSE) level_d = sync_q;
            else                              run_d   = run_q + 1'b1;
        end
    end

    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            meta_q  <= SL_IDLE_LVL;
            sync_q  <= SL_IDLE_LVL;
            level_q <= SL_IDLE_LVL;
            run_q   <= '0;
        end else begin
            meta_q  <= line_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/sl_rx_deframer.sv
// SL receive deframer: decodes filtered two-wire pulses into bits and stop
// markers, checks length and odd parity, and writes good words into the FIFO.
module sl_rx_deframer
    import sl_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int MIN_PULSE   = 2,
    parameter int BIT_TIMEOUT = 255
) (
    input  logic                 wr_clk,
    input  logic                 rd_rst_n,
    input  logic                 sl0,
    input  logic                 sl1,
    input  logic                 wr_full,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic                 wr_inc,
    output logic                 parity_err,
    output logic                 len_err,
    output logic                 overflow
);

    localparam int FRAME_BITS = DATA_SIZE + 1;
    localparam int CNT_W      = $clog2(DATA_SIZE + 3);
    localparam int TMO_W      = $clog2(BIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(DATA_SIZE + 2);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(BIT_TIMEOUT);

    logic lvl0, lvl1, lo0, lo1;

    sl_line_filter #(.MIN_PULSE(MIN_PULSE)) u_filt0 (
        .wr_clk(wr_clk), .rd_rst_n(rd_rst_n), .line_i(sl0), .level_o(lvl0)
    );
    sl_line_filter #(.MIN_PULSE(MIN_PULSE)) u_filt1 (
        .wr_clk(wr_clk), .rd_rst_n(rd_rst_n), .line_i(sl1), .level_o(lvl1)
    );

    assign lo0 = (lvl0 != SL_IDLE_LVL);
    assign lo1 = (lvl1 != SL_IDLE_LVL);

    sl_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [FRAME_BITS-1:0] sr_q;
    logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
    logic                wr_inc_q, wr_inc_d, par_q, par_d, len_q, len_d, ovf_q, ovf_d;
    logic                timed, expired, settled, both_high;
    logic                shift_en, shift_bit, eval_en, abort;
    sl_outcome_e         outcome;

    assign both_high = !lo0 && !lo1;
    assign timed     = (state_q == ST_GAP) || (state_q == ST_PULSE0) || (state_q == ST_PULSE1);
    assign expired   = timed && (tmo_q == TMO_LIMIT);
    // After reset the synchronisers still show idle; the lines must stay high
    // longer than the sync+filter latency before a held-low line is trusted as idle.
    assign settled   = int'(tmo_q) >= MIN_PULSE + 3;

    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) state_q <= ST_WAIT_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_IDLE: if (both_high && settled) state_d = ST_IDLE;
            ST_IDLE, ST_GAP: begin
                if (lo0 && lo1) state_d = ST_STOP;
                else if (lo0)   state_d = ST_PULSE0;
                else if (lo1)   state_d = ST_PULSE1;
            end
            ST_PULSE0: if (lo1) state_d = ST_STOP; else if (!lo0) state_d = ST_GAP;
            ST_PULSE1: if (lo0) state_d = ST_STOP; else if (!lo1) state_d = ST_GAP;
            ST_STOP:   if (both_high) state_d = ST_IDLE;
            default:   state_d = ST_WAIT_IDLE;
        endcase
        if (expired) state_d = ST_WAIT_IDLE;
    end

    always_comb begin
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        eval_en   = 1'b0;
        abort     = expired;
        case (state_q)
            ST_PULSE0: shift_en = both_high;
            ST_PULSE1: begin
                shift_en  = both_high;
                shift_bit = 1'b1;
            end
            ST_STOP:   eval_en = both_high;
            default:   ;
        endcase
        if (expired) shift_en = 1'b0;
    end

    assign outcome = sl_frame_outcome(cnt_q == CNT_FRAME, ^sr_q, wr_full);

    always_comb begin
        cnt_d = cnt_q;
        if (eval_en || abort || state_q == ST_WAIT_IDLE) cnt_d = '0;
        else if (shift_en && cnt_q != CNT_SAT)           cnt_d = cnt_q + 1'b1;

        tmo_d = '0;
        if (state_d != state_q)                 tmo_d = '0;
        else if (timed)                         tmo_d = tmo_q + 1'b1;
        else if (state_q == ST_WAIT_IDLE && both_high) tmo_d = settled ? tmo_q : tmo_q + 1'b1;

        wr_inc_d  = eval_en && (outcome == OUT_WRITE);
        par_d     = eval_en && (outcome == OUT_PARITY_ERR);
        len_d     = abort || (eval_en && (outcome == OUT_LEN_ERR));
        ovf_d     = eval_en && (outcome == OUT_OVERFLOW);
        wr_data_d = wr_inc_d ? sr_q[FRAME_BITS-1:1] : wr_data_q;
    end

    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            cnt_q     <= '0;
            tmo_q     <= '0;
            wr_data_q <= '0;
            wr_inc_q  <= 1'b0;
            par_q     <= 1'b0;
            len_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            wr_data_q <= wr_data_d;
            wr_inc_q  <= wr_inc_d;
            par_q     <= par_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
        end
    end

    // First received bit ends up in the MSB; the parity bit sits in bit 0.
    always_ff @(posedge wr_clk) begin
        if (shift_en) sr_q <= {sr_q[FRAME_BITS-2:0], shift_bit};
    end

    assign wr_data    = wr_data_q;
    assign wr_inc     = wr_inc_q;
    assign parity_err = par_q;
    assign len_err    = len_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_sl_rx_deframer.sv
// Directed bench for sl_rx_deframer with a frame-level outcome model and scoreboard.
module tb_sl_rx_deframer;

    localparam int DATA_SIZE = 8;
    localparam logic [3:0] EV_WR  = 4'b1000;
    localparam logic [3:0] EV_PAR = 4'b0100;
    localparam logic [3:0] EV_LEN = 4'b0010;
    localparam logic [3:0] EV_OVF = 4'b0001;

    logic       wr_clk   = 1'b0;
    logic       rd_rst_n = 1'b0;
    logic       sl0      = 1'b1;
    logic       sl1      = 1'b1;
    logic       wr_full  = 1'b0;
    logic [7:0] wr_data;
    logic       wr_inc, parity_err, len_err, overflow;

    int errors = 0;
    int checks = 0;

    typedef int bitq_t[$];
    typedef struct {
        logic [3:0] ev;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_data = 8'h00;

    always #5 wr_clk = ~wr_clk;

    sl_rx_deframer #(.DATA_SIZE(8), .MIN_PULSE(2), .BIT_TIMEOUT(255)) dut (
        .wr_clk(wr_clk), .rd_rst_n(rd_rst_n), .sl0(sl0), .sl1(sl1), .wr_full(wr_full),
        .wr_data(wr_data), .wr_inc(wr_inc), .parity_err(parity_err),
        .len_err(len_err), .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Frame outcome from the line protocol rules: length, odd parity, FIFO space.
    function automatic exp_t model_frame(input bitq_t bits, input logic full);
        exp_t e;
        int   ones;
        ones   = 0;
        e.data = 8'h00;
        foreach (bits[i]) ones += bits[i];
        if (bits.size() != DATA_SIZE + 1) e.ev = EV_LEN;
        else if (ones % 2 == 0)           e.ev = EV_PAR;
        else if (full)                    e.ev = EV_OVF;
        else begin
            e.ev = EV_WR;
            for (int i = 0; i < DATA_SIZE; i++) e.data = {e.data[6:0], bits[i][0]};
        end
        return e;
    endfunction

    function automatic bitq_t mk(input logic [7:0] d, input int par);
        bitq_t q;
        for (int i = 7; i >= 0; i--) q.push_back(int'(d[i]));
        q.push_back(par);
        return q;
    endfunction

    // Scoreboard: every asserted outcome pulse must match the next expected frame.
    always @(negedge wr_clk) begin
        logic [3:0] ev;
        exp_t       e;
        ev = {wr_inc, parity_err, len_err, overflow};
        if (!rd_rst_n) begin
            model_data = 8'h00;
            check("reset_pulses", 32'(ev), 32'h0);
            check("reset_wr_data", 32'(wr_data), 32'h0);
        end else begin
            if (ev != 4'b0000) begin
                if (exp_q.size() == 0) check("unexpected_event", 32'(ev), 32'h0);
                else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(ev), 32'(e.ev));
                    if (e.ev == EV_WR) model_data = e.data;
                end
            end
            check("wr_data_hold", 32'(wr_data), 32'(model_data));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge wr_clk);
            #1;
        end
    endtask

    task automatic send_bit(input int b, input bit glitch);
        if (b != 0) sl1 = 1'b0; else sl0 = 1'b0;
        step(3);
        sl0 = 1'b1;
        sl1 = 1'b1;
        step(3);
        if (glitch) begin
            sl0 = 1'b0; step(1); sl0 = 1'b1; step(2);
            sl1 = 1'b0; step(1); sl1 = 1'b1; step(3);
        end
    endtask

    task automatic send_stop(input bit skew);
        sl0 = 1'b0;
        if (skew) step(1);
        sl1 = 1'b0;
        step(4);
        sl0 = 1'b1;
        sl1 = 1'b1;
        step(12);
    endtask

    task automatic send_frame(input bitq_t bits, input bit skew, input bit glitch, input string name);
        exp_q.push_back(model_frame(bits, wr_full));
        foreach (bits[i]) send_bit(bits[i], glitch);
        send_stop(skew);
        check({name, "_outcome_seen"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        exp_t  m;
        bitq_t b;

        m = model_frame(mk(8'hA5, 1), 1'b0);
        check("model_a5_kind", 32'(m.ev), 32'(EV_WR));
        check("model_a5_data", 32'(m.data), 32'hA5);
        m = model_frame(mk(8'hA5, 0), 1'b0);
        check("model_a5_par", 32'(m.ev), 32'(EV_PAR));
        m = model_frame(mk(8'h3C, 1), 1'b1);
        check("model_3c_full", 32'(m.ev), 32'(EV_OVF));

        step(3);
        rd_rst_n = 1'b1;
        step(10);

        send_frame(mk(8'hA5, 1), 1'b0, 1'b0, "t1_a5");
        check("t1_wr_data", 32'(wr_data), 32'hA5);

        send_frame(mk(8'hA5, 0), 1'b0, 1'b0, "t2_parity");
        check("t2_wr_data_kept", 32'(wr_data), 32'hA5);

        b = mk(8'hA5, 1);
        void'(b.pop_back());
        send_frame(b, 1'b0, 1'b0, "t3_short");
        b = mk(8'hA5, 1);
        b.push_back(0);
        send_frame(b, 1'b0, 1'b0, "t3_long");

        wr_full = 1'b1;
        send_frame(mk(8'h3C, 1), 1'b0, 1'b0, "t4_full");
        check("t4_wr_data_kept", 32'(wr_data), 32'hA5);
        wr_full = 1'b0;
        send_frame(mk(8'h3C, 1), 1'b0, 1'b0, "t4_retry");
        check("t4_wr_data", 32'(wr_data), 32'h3C);

        send_frame(mk(8'h5A, 1), 1'b0, 1'b1, "t5_glitch");
        check("t5_glitch_data", 32'(wr_data), 32'h5A);
        send_frame(mk(8'hC3, 1), 1'b1, 1'b0, "t5_skew");
        check("t5_skew_data", 32'(wr_data), 32'hC3);

        b.delete();
        send_frame(b, 1'b0, 1'b0, "t5_stop_a");
        send_frame(b, 1'b1, 1'b0, "t5_stop_b");

        exp_q.push_back('{ev: EV_LEN, data: 8'h00});
        send_bit(1, 1'b0);
        send_bit(0, 1'b0);
        send_bit(1, 1'b0);
        step(300);
        check("t6_timeout_seen", 32'(exp_q.size()), 32'h0);
        send_frame(mk(8'h81, 1), 1'b0, 1'b0, "t6_after_tmo");
        check("t6_wr_data", 32'(wr_data), 32'h81);

        send_bit(1, 1'b0);
        send_bit(1, 1'b0);
        send_bit(0, 1'b0);
        sl0 = 1'b0;
        step(1);
        rd_rst_n = 1'b0;
        step(2);
        rd_rst_n = 1'b1;
        step(10);
        sl0 = 1'b1;
        step(12);
        check("t6_rst_wr_data", 32'(wr_data), 32'h0);
        send_frame(mk(8'h42, 1), 1'b0, 1'b0, "t6_after_rst");
        check("t6_rst_resume", 32'(wr_data), 32'h42);

        step(5);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
